bias_load_ctrl: RTL

Sequencer that loads per-lane bias values from the bias buffer SRAM into the Bias+ReLU SIMD stage at the systolic array output. It accepts one load command per output tile, streams `count` consecutive bias words from memory, and converts them into the SIMD's one-hot lane write port. It raises `busy` so the tile scheduler holds array output until the new biases are in place.

---
 rtl/npu_bias_pkg.sv | 23 ++
 rtl/lane_onehot_dec.sv | 28 ++
 rtl/bias_load_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/npu_bias_pkg.sv
// rtl/npu_bias_pkg.sv - shared types and constants for the bias load path
// Purpose: FSM state encoding, default sizing constants and the lane-index
//          width helper used by bias_load_ctrl and lane_onehot_dec.
// Ports:   none (package).
package npu_bias_pkg;

  localparam int DEF_ARRAY_N    = 16;
  localparam int DEF_OUT_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } bias_state_e;

  // One extra bit so that a full-array count (== ARRAY_N) is representable.
  function automatic int lane_idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/lane_onehot_dec.sv
// rtl/lane_onehot_dec.sv - lane index to one-hot lane select decoder
// Purpose: combinational decode of a lane index into an ARRAY_N-bit one-hot
//          vector; all zeros when disabled or when idx >= ARRAY_N.
// Ports:   idx    in  lane index (lane_idx_w(ARRAY_N) bits)
//          en     in  decode enable
//          onehot out ARRAY_N-bit one-hot select
module lane_onehot_dec
  import npu_bias_pkg::*;
#(
  parameter int ARRAY_N = DEF_ARRAY_N
) (
  input  logic [lane_idx_w(ARRAY_N)-1:0] idx,
  input  logic                           en,
  output logic [ARRAY_N-1:0]             onehot
);

  localparam int IW = lane_idx_w(ARRAY_N);

  // Equality per lane rather than a shift, so out-of-range indices
  // naturally decode to zero and never alias onto a real lane.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < ARRAY_N; i++) begin
      onehot[i] = en && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/bias_load_ctrl.sv
// rtl/bias_load_ctrl.sv - bias buffer to Bias+ReLU SIMD lane load sequencer
// Purpose: accepts one load command per tile, streams up to ARRAY_N bias words
//          from the bias SRAM and drives the SIMD one-hot lane write port.
// Option:  BIAS_LOAD_CTRL_ZERO_FILL_EN - when defined, lanes beyond the
//          command count are written with zero in the FILL state.
// Ports:   clk, reset           clock, async active-high reset
//          cmd_valid/cmd_ready  load command handshake (ready only in IDLE)
//          cmd_base_addr        buffer address of lane 0's bias
//          cmd_count            lanes to load (clamped to ARRAY_N)
//          mem_rd_en/addr       buffer read strobe and address
//          mem_rd_data          read data, valid one cycle after the strobe
//          w_en/w_index/w_data  one-hot lane write port into the SIMD stage
//          busy, done           load in progress / completion pulse
module bias_load_ctrl
  import npu_bias_pkg::*;
#(
  parameter int ARRAY_N    = DEF_ARRAY_N,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ADDR_WIDTH-1:0]          cmd_base_addr,
  input  logic [lane_idx_w(ARRAY_N)-1:0] cmd_count,
  output logic                           mem_rd_en,
  output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
  input  logic [OUT_WIDTH-1:0]           mem_rd_data,
  output logic [lane_idx_w(ARRAY_N)-1:0] w_index,
  output logic [OUT_WIDTH-1:0]           w_data,
  output logic [ARRAY_N-1:0]             w_en,
  output logic                           busy,
  output logic                           done
);

  localparam int            IW    = lane_idx_w(ARRAY_N);
  localparam logic [IW-1:0] LANES = IW'(ARRAY_N);
  localparam logic [IW-1:0] ONE   = IW'(1);

  bias_state_e        state;
  logic [IW-1:0]      cnt;       // lane whose read/fill is issued this cycle
  logic [IW-1:0]      n_lanes;   // latched, clamped lane count
  logic [IW-1:0]      n_eff;
  logic               issue;     // a lane write is launched this cycle
  logic               issue_mem; // ... and its data comes from the buffer
  logic               wr_mem;    // current write carries buffer data
  logic [ARRAY_N-1:0] lane_sel;

  assign n_eff     = (cmd_count > LANES) ? LANES : cmd_count;
  assign issue_mem = (state == S_READ) && (cnt < n_lanes);
`ifdef BIAS_LOAD_CTRL_ZERO_FILL_EN
  assign issue     = issue_mem || ((state == S_FILL) && (cnt < LANES));
`else
  assign issue     = issue_mem;
`endif

  lane_onehot_dec #(.ARRAY_N(ARRAY_N)) u_lane_dec (
    .idx    (cnt),
    .en     (issue),
    .onehot (lane_sel)
  );

  // Status flags are pure decodes of the state register.
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Buffer data arrives in the same cycle the registered lane strobe is
  // presented, so the data path is a gated pass-through; fill writes and
  // idle cycles present zero.
  assign w_data = wr_mem ? mem_rd_data : '0;

  // READ and FILL each spend one extra cycle after their last issue (cnt at
  // its limit) so the final registered write is visible before DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      n_lanes     <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      w_en        <= '0;
      w_index     <= '0;
      wr_mem      <= 1'b0;
    end else begin
      w_en        <= lane_sel;
      w_index     <= issue ? cnt : '0;
      wr_mem      <= issue_mem;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (cmd_valid) begin
            n_lanes <= n_eff;
            if (n_eff != '0) begin
              state       <= S_READ;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= cmd_base_addr;
            end else begin
`ifdef BIAS_LOAD_CTRL_ZERO_FILL_EN
              state <= S_FILL;
`else
              state <= S_DONE;
`endif
            end
          end
        end
        S_READ: begin
          cnt <= cnt + ONE;
          if ((cnt + ONE) < n_lanes) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= mem_rd_addr + ADDR_WIDTH'(1);
          end
`ifdef BIAS_LOAD_CTRL_ZERO_FILL_EN
          if (((cnt + ONE) == n_lanes) && (n_lanes < LANES)) begin
            state <= S_FILL;
          end else if (cnt == n_lanes) begin
            state <= S_DONE;
          end
`else
          if (cnt == n_lanes) begin
            state <= S_DONE;
          end
`endif
        end
`ifdef BIAS_LOAD_CTRL_ZERO_FILL_EN
        S_FILL: begin
          cnt <= cnt + ONE;
          if (cnt == LANES) begin
            state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
